// File: rtl/note_lookup_sched.sv
// note_lookup_sched: round-robin time-sharing of one clocked note-to-half-period
// lookup between NVOICE voices. Optional feature macro: LAST_NOTE_BYPASS_EN
// (skip the lookup when the granted note equals the note already on lutNote_o).
module note_lookup_sched #(
  parameter int unsigned NVOICE  = 4,
  parameter int unsigned BW      = 16,
  parameter int unsigned LUT_LAT = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NVOICE-1:0]   req_i,
  input  logic [8*NVOICE-1:0] note_i,
  output logic [NVOICE-1:0]   done_o,
  output logic [BW-1:0]       period_o,
  output logic                busy_o,
  output logic [7:0]          lutNote_o,
  input  logic [BW-1:0]       lutPeriod_i
);

  localparam int unsigned IdxW = (NVOICE > 1) ? $clog2(NVOICE) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [IdxW-1:0]   r_rr_ptr, w_rr_ptr_d;
  logic [IdxW-1:0]   r_grant, w_grant_d;
  logic [2:0]        r_wait_cnt, w_wait_cnt_d;
  logic [7:0]        r_lut_note, w_lut_note_d;
  logic [BW-1:0]     r_period, w_period_d;
  logic [NVOICE-1:0] r_done, w_done_d;

  logic              w_found;
  logic [IdxW-1:0]   w_pick;
  logic [7:0]        w_pick_note;
  logic              w_bypass;
  int unsigned       w_idx;

  function automatic logic [NVOICE-1:0] onehot(input logic [IdxW-1:0] idx);
    return NVOICE'(1) << idx;
  endfunction

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    return (idx == IdxW'(NVOICE - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Round-robin search: first requesting voice at or above rrPtr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int unsigned i = 0; i < NVOICE; i++) begin
      w_idx = (32'(r_rr_ptr) + i) % NVOICE;
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_pick  = IdxW'(w_idx);
      end
    end
  end

  // Note of the voice that would be granted this cycle.
  always_comb begin
    w_pick_note = '0;
    for (int unsigned v = 0; v < NVOICE; v++) begin
      if (w_pick == IdxW'(v)) w_pick_note = note_i[8*v +: 8];
    end
  end

`ifdef LAST_NOTE_BYPASS_EN
  logic r_last_valid;

  // lastValid goes high on entry to DONE and stays until reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_valid <= 1'b0;
    end else if (w_state_d == StDone && r_state != StDone) begin
      r_last_valid <= 1'b1;
    end
  end

  assign w_bypass = r_last_valid && (w_pick_note == r_lut_note);
`else
  assign w_bypass = 1'b0;
`endif

  // Next-state and registered-output logic of the scheduler FSM.
  always_comb begin
    w_state_d    = r_state;
    w_rr_ptr_d   = r_rr_ptr;
    w_grant_d    = r_grant;
    w_wait_cnt_d = r_wait_cnt;
    w_lut_note_d = r_lut_note;
    w_period_d   = r_period;
    w_done_d     = '0;
    case (r_state)
      StIdle: begin
        if (w_found) begin
          w_grant_d = w_pick;
          if (w_bypass) begin
            // Lookup already holds this note: complete now, keep period_o.
            w_done_d   = onehot(w_pick);
            w_rr_ptr_d = next_idx(w_pick);
            w_state_d  = StDone;
          end else begin
            w_lut_note_d = w_pick_note;
            w_wait_cnt_d = 3'(LUT_LAT);
            w_state_d    = StWait;
          end
        end
      end
      StWait: begin
        if (r_wait_cnt == '0) begin
          w_period_d = lutPeriod_i;
          w_done_d   = onehot(r_grant);
          w_rr_ptr_d = next_idx(r_grant);
          w_state_d  = StDone;
        end else begin
          w_wait_cnt_d = r_wait_cnt - 3'd1;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_wait_cnt <= '0;
      r_lut_note <= '0;
      r_period   <= '0;
      r_done     <= '0;
    end else begin
      r_state    <= w_state_d;
      r_rr_ptr   <= w_rr_ptr_d;
      r_grant    <= w_grant_d;
      r_wait_cnt <= w_wait_cnt_d;
      r_lut_note <= w_lut_note_d;
      r_period   <= w_period_d;
      r_done     <= w_done_d;
    end
  end

  assign done_o    = r_done;
  assign period_o  = r_period;
  assign busy_o    = (r_state != StIdle);
  assign lutNote_o = r_lut_note;

endmodule

// File: tb/tb_note_lookup_sched.sv
// Self-checking bench for note_lookup_sched: directed table + hand sequences,
// then random traffic against a transaction-level reference model.
module tb_note_lookup_sched;

  localparam int NV  = 4;
  localparam int BW  = 16;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NV-1:0]   req;
  logic [8*NV-1:0] note;
  logic [NV-1:0]   done;
  logic [BW-1:0]   period;
  logic            busy;
  logic [7:0]      lut_note;
  logic [BW-1:0]   lut_period;
  logic [BW-1:0]   lp1, lp2;

  note_lookup_sched #(.NVOICE(NV), .BW(BW), .LUT_LAT(LAT)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .note_i     (note),
    .done_o     (done),
    .period_o   (period),
    .busy_o     (busy),
    .lutNote_o  (lut_note),
    .lutPeriod_i(lut_period)
  );

  always #5 clk = ~clk;

  // Shared lookup model: period = 1000 + note, two edges of latency.
  always @(posedge clk) begin
    lp1 <= 16'd1000 + {8'd0, lut_note};
    lp2 <= lp1;
  end
  assign lut_period = lp2;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model state (transaction level, cycle numbers as plain ints).
  bit         m_on = 0;
  int         m_rr, m_start, m_free, m_done_cyc, m_done_v;
  bit         m_last;
  logic [7:0] m_lut;
  int         m_period, m_pend;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_note(input int v, input int n);
    note[8*v +: 8] = 8'(n);
  endtask

  function automatic int note_of(input int v);
    logic [8*NV-1:0] tmp;
    tmp = note;
    return int'(tmp[8*v +: 8]);
  endfunction

  // Model reaction to the edge ending the current cycle (inputs of this cycle).
  task automatic model_edge();
    int v;
    if (cyc >= m_free && req != '0) begin
      v = -1;
      for (int i = 0; i < NV; i++) begin
        if (v < 0 && req[(m_rr + i) % NV]) v = (m_rr + i) % NV;
      end
      m_done_v = v;
      m_start  = cyc + 1;
`ifdef LAST_NOTE_BYPASS_EN
      if (m_last && note_of(v) == int'(m_lut)) begin
        m_done_cyc = cyc + 1;
        m_pend     = m_period;
        m_free     = cyc + 2;
      end else
`endif
      begin
        m_lut      = 8'(note_of(v));
        m_done_cyc = cyc + LAT + 2;
        m_pend     = 1000 + note_of(v);
        m_free     = cyc + LAT + 3;
      end
      m_rr   = (v + 1) % NV;
      m_last = 1'b1;
    end
  endtask

  task automatic step();
    if (m_on) model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    note = '0;
    @(negedge clk);
    @(negedge clk);
    cyc += 2;
    rst = 1'b0;
    m_rr = 0; m_start = 0; m_free = 0; m_done_cyc = -1; m_done_v = 0;
    m_last = 1'b0; m_lut = '0; m_period = 0; m_pend = 0;
    step();
  endtask

  // Step until a done pulse; optionally drop that voice's request.
  task automatic wait_done(input int bound, input bit drop, output int v, output int at);
    v  = -1;
    at = -1;
    for (int k = 0; k < bound; k++) begin
      step();
      if (done != '0) begin
        for (int i = 0; i < NV; i++) if (done[i]) v = i;
        at = cyc;
        if (drop) req[v] = 1'b0;
        return;
      end
    end
    n_checks++;
    n_err++;
    $display("FAIL wait_done: no done within %0d cycles (cycle %0d)", bound, cyc);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  n0;
    logic [3:0]  e_done;
    logic        e_busy;
    logic [7:0]  e_lut;
    logic [15:0] e_per;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int v, at, t0, prev, exp_v;
    logic [NV-1:0] exp_done;

    // Single request, voice 0 note 69.
    tbl[0] = '{4'b0001, 8'd69, 4'b0000, 1'b0, 8'd0,  16'd0};
    tbl[1] = '{4'b0001, 8'd69, 4'b0000, 1'b1, 8'd69, 16'd0};
    tbl[2] = '{4'b0001, 8'd69, 4'b0000, 1'b1, 8'd69, 16'd0};
    tbl[3] = '{4'b0001, 8'd69, 4'b0000, 1'b1, 8'd69, 16'd0};
    tbl[4] = '{4'b0000, 8'd69, 4'b0001, 1'b1, 8'd69, 16'd1069};
    tbl[5] = '{4'b0000, 8'd69, 4'b0000, 1'b0, 8'd69, 16'd1069};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_done[%0d]", i), int'(done), int'(tbl[i].e_done));
      chk($sformatf("t1_busy[%0d]", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("t1_lut[%0d]", i), int'(lut_note), int'(tbl[i].e_lut));
      chk($sformatf("t1_period[%0d]", i), int'(period), int'(tbl[i].e_per));
      req = tbl[i].req;
      set_note(0, int'(tbl[i].n0));
      step();
    end

    // All four voices at once: served 0,1,2,3 five cycles apart.
    do_reset();
    for (int i = 0; i < NV; i++) set_note(i, 10 * (i + 1));
    req = 4'b1111;
    t0  = cyc;
    for (int k = 0; k < NV; k++) begin
      wait_done(20, 1'b1, v, at);
      chk("t2_voice", v, k);
      chk("t2_onehot", int'(done), 1 << k);
      chk("t2_time", at, t0 + LAT + 2 + (LAT + 3) * k);
      chk("t2_period", int'(period), 1000 + 10 * (k + 1));
    end
    step();
    chk("t2_idle_busy", int'(busy), 0);

    // Voices 1 and 3 hold requests: grants alternate 1,3,1,3.
    do_reset();
    set_note(1, 11);
    set_note(3, 33);
    req  = 4'b1010;
    prev = cyc - 1;
    for (int k = 0; k < 4; k++) begin
      wait_done(20, 1'b0, v, at);
      exp_v = (k % 2 == 0) ? 1 : 3;
      chk("t3_voice", v, exp_v);
      chk("t3_period", int'(period), 1000 + ((exp_v == 1) ? 11 : 33));
      if (k > 0) chk("t3_gap", at - prev, LAT + 3);
      prev = at;
    end
    req = '0;

    // Note change and request drop during WAIT are ignored.
    do_reset();
    set_note(0, 50);
    req = 4'b0001;
    step();
    step();
    set_note(0, 60);
    req = '0;
    step();
    step();
    chk("t4_done", int'(done), 1);
    chk("t4_period", int'(period), 1050);
    step();
    chk("t4_done_clear", int'(done), 0);
    step();
    chk("t4_idle", int'(busy), 0);

    // Reset mid-WAIT: abandoned grant, then re-grant of held request.
    do_reset();
    set_note(2, 77);
    req = 4'b0100;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("t5_rst_done", int'(done), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_lut", int'(lut_note), 0);
    chk("t5_rst_period", int'(period), 0);
    step();
    rst = 1'b0;
    t0  = cyc;
    for (int k = 1; k < 4; k++) begin
      step();
      chk("t5_no_done", int'(done), 0);
    end
    step();
    chk("t5_done", int'(done), 4);
    chk("t5_period", int'(period), 1077);
    chk("t5_time", cyc - t0, 4);
    req = '0;
    step();

`ifdef LAST_NOTE_BYPASS_EN
    // Same note as the last lookup: done on the cycle after the grant.
    do_reset();
    set_note(0, 69);
    req = 4'b0001;
    wait_done(20, 1'b1, v, at);
    chk("t6_first", int'(period), 1069);
    step();
    set_note(2, 69);
    req = 4'b0100;
    step();
    chk("t6_done", int'(done), 4);
    chk("t6_period", int'(period), 1069);
    chk("t6_lut", int'(lut_note), 69);
    req = '0;
    step();
    chk("t6_done_clear", int'(done), 0);
`endif

    // Random traffic against the reference model.
    do_reset();
    m_on = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (cyc == m_done_cyc) m_period = m_pend;
      exp_done = (cyc == m_done_cyc) ? NV'(1 << m_done_v) : '0;
      chk("rnd_done", int'(done), int'(exp_done));
      chk("rnd_period", int'(period), m_period);
      chk("rnd_busy", int'(busy), int'(cyc >= m_start && cyc < m_free));
      chk("rnd_lut", int'(lut_note), int'(m_lut));
      for (int i = 0; i < NV; i++) begin
        if (exp_done[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          set_note(i, 60 + int'($urandom_range(0, 3)));
        end
      end
      step();
    end
    m_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
